controlador_rega: RTL and testbench

- Irrigation sequencer FSM that decides when to water and which method to use (drip = gotejamento, sprinkler = aspersao).
- Drives the pump and the two valves.
- Publishes the active method as the gotejamento/aspersao flags consumed by encoderTipoRega for the 7-segment display.
- Sits between the sensor inputs (soil moisture, tank level, rain) and the actuator/display outputs.

---
 rtl/controlador_rega_pkg.sv | 32 +++
 rtl/controlador_rega_divisor_tick.sv | 30 +++
 rtl/controlador_rega.sv | 168 ++++++++++++++++
 tb/tb_controlador_rega.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/controlador_rega_pkg.sv
// rtl/controlador_rega_pkg.sv - shared state, moisture and mode encodings for the irrigation sequencer
package controlador_rega_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRIME    = 3'd1,
      ST_IRRIGATE = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } estado_t;

   localparam logic [1:0] UMID_SECO    = 2'b00;
   localparam logic [1:0] UMID_BAIXA   = 2'b01;
   localparam logic [1:0] UMID_MEDIA   = 2'b10;
   localparam logic [1:0] UMID_MOLHADO = 2'b11;

   typedef enum logic [1:0] {
      MODO_NENHUM      = 2'b00,
      MODO_GOTEJAMENTO = 2'b01,
      MODO_ASPERSAO    = 2'b10
   } modo_t;

   // A phase programmed with zero ticks still lasts one tick.
   function automatic int ticks_efetivos(input int t);
      return (t < 1) ? 1 : t;
   endfunction

   function automatic int maior(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/controlador_rega_divisor_tick.sv
// rtl/controlador_rega_divisor_tick.sv - prescaler emitting a one-cycle tick every TICK_DIV clocks
module divisor_tick #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   assign wrap = (cnt_q == ULTIMO);
   assign tick = wrap;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || wrap) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/controlador_rega.sv
// rtl/controlador_rega.sv - irrigation sequencer driving pump, drip/sprinkler valves and display flags
// Optional rain lockout enabled with `define RAIN_LOCKOUT_EN.
module controlador_rega
   import controlador_rega_pkg::*;
#(
   parameter int TICK_DIV    = 50000000,
   parameter int PRIME_TICKS = 3,
   parameter int DRIP_TICKS  = 20,
   parameter int SPRAY_TICKS = 10,
   parameter int COOL_TICKS  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inicio,
   input  logic       parar,
   input  logic [1:0] umidade,
   input  logic       nivelBaixo,
   input  logic       chuva,
   output logic       bomba,
   output logic       valvulaGotejamento,
   output logic       valvulaAspersao,
   output logic       gotejamento,
   output logic       aspersao,
   output logic       alarme,
   output logic       ocupado,
   output logic [2:0] estado
);

   localparam int PRIME_N = ticks_efetivos(PRIME_TICKS);
   localparam int DRIP_N  = ticks_efetivos(DRIP_TICKS);
   localparam int SPRAY_N = ticks_efetivos(SPRAY_TICKS);
   localparam int COOL_N  = ticks_efetivos(COOL_TICKS);
   localparam int MAX_N   = maior(maior(PRIME_N, DRIP_N), maior(SPRAY_N, COOL_N));
   localparam int TCW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   localparam logic [TCW-1:0] PRIME_FIM = TCW'(PRIME_N - 1);
   localparam logic [TCW-1:0] DRIP_FIM  = TCW'(DRIP_N - 1);
   localparam logic [TCW-1:0] SPRAY_FIM = TCW'(SPRAY_N - 1);
   localparam logic [TCW-1:0] COOL_FIM  = TCW'(COOL_N - 1);

   estado_t        estado_q, estado_d;
   modo_t          modo_q, modo_d;
   logic [TCW-1:0] conta_q, conta_d;
   logic [TCW-1:0] limite;
   logic           tick, limpa, fim_fase, chuva_bloqueio;

   logic bomba_q, bomba_d, vgot_q, vgot_d, vasp_q, vasp_d;
   logic got_q, got_d, asp_q, asp_d, alarme_q, alarme_d, ocupado_q, ocupado_d;

`ifdef RAIN_LOCKOUT_EN
   assign chuva_bloqueio = chuva;
`else
   logic unused_chuva;
   assign unused_chuva   = chuva;
   assign chuva_bloqueio = 1'b0;
`endif

   divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor (
      .clk   (clk),
      .reset (reset),
      .clear (limpa),
      .tick  (tick)
   );

   always_comb begin
      limite = COOL_FIM;
      case (estado_q)
         ST_PRIME:    limite = PRIME_FIM;
         ST_IRRIGATE: limite = (modo_q == MODO_ASPERSAO) ? SPRAY_FIM : DRIP_FIM;
         default:     limite = COOL_FIM;
      endcase
   end

   assign fim_fase = tick && (conta_q == limite);

   // Next-state decision; abort order is nivelBaixo, then parar, then rain, then timer/moisture.
   always_comb begin
      estado_d = estado_q;
      modo_d   = modo_q;
      case (estado_q)
         ST_IDLE: begin
            if (inicio && !parar && (umidade != UMID_MOLHADO) && !chuva_bloqueio) begin
               modo_d   = (umidade == UMID_SECO) ? MODO_ASPERSAO : MODO_GOTEJAMENTO;
               estado_d = nivelBaixo ? ST_FAULT : ST_PRIME;
            end
         end
         ST_PRIME: begin
            if (nivelBaixo)                  estado_d = ST_FAULT;
            else if (parar || chuva_bloqueio) estado_d = ST_COOLDOWN;
            else if (fim_fase)               estado_d = ST_IRRIGATE;
         end
         ST_IRRIGATE: begin
            if (nivelBaixo)                                  estado_d = ST_FAULT;
            else if (parar || chuva_bloqueio)                estado_d = ST_COOLDOWN;
            else if (fim_fase || (umidade == UMID_MOLHADO))  estado_d = ST_COOLDOWN;
         end
         ST_COOLDOWN: begin
            if (nivelBaixo) estado_d = ST_FAULT;
            else if (fim_fase) begin
               estado_d = ST_IDLE;
               modo_d   = MODO_NENHUM;
            end
         end
         ST_FAULT: begin
            if (parar && !nivelBaixo) begin
               estado_d = ST_IDLE;
               modo_d   = MODO_NENHUM;
            end
         end
         default: begin
            estado_d = ST_IDLE;
            modo_d   = MODO_NENHUM;
         end
      endcase

      // Every state entry restarts both the prescaler and the tick count.
      limpa   = (estado_d != estado_q);
      conta_d = conta_q;
      if (limpa)     conta_d = '0;
      else if (tick) conta_d = conta_q + 1'b1;
   end

   always_comb begin
      ocupado_d = (estado_d == ST_PRIME) || (estado_d == ST_IRRIGATE) || (estado_d == ST_COOLDOWN);
      bomba_d   = (estado_d == ST_PRIME) || (estado_d == ST_IRRIGATE);
      vgot_d    = ((estado_d == ST_IRRIGATE) || (estado_d == ST_COOLDOWN)) && (modo_d == MODO_GOTEJAMENTO);
      vasp_d    = ((estado_d == ST_IRRIGATE) || (estado_d == ST_COOLDOWN)) && (modo_d == MODO_ASPERSAO);
      got_d     = ocupado_d && (modo_d == MODO_GOTEJAMENTO);
      asp_d     = ocupado_d && (modo_d == MODO_ASPERSAO);
      alarme_d  = (estado_d == ST_FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q  <= ST_IDLE;
         modo_q    <= MODO_NENHUM;
         conta_q   <= '0;
         bomba_q   <= 1'b0;
         vgot_q    <= 1'b0;
         vasp_q    <= 1'b0;
         got_q     <= 1'b0;
         asp_q     <= 1'b0;
         alarme_q  <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         modo_q    <= modo_d;
         conta_q   <= conta_d;
         bomba_q   <= bomba_d;
         vgot_q    <= vgot_d;
         vasp_q    <= vasp_d;
         got_q     <= got_d;
         asp_q     <= asp_d;
         alarme_q  <= alarme_d;
         ocupado_q <= ocupado_d;
      end
   end

   assign bomba              = bomba_q;
   assign valvulaGotejamento = vgot_q;
   assign valvulaAspersao    = vasp_q;
   assign gotejamento        = got_q;
   assign aspersao           = asp_q;
   assign alarme             = alarme_q;
   assign ocupado            = ocupado_q;
   assign estado             = estado_q;

endmodule

// File: tb/tb_controlador_rega.sv
// tb/tb_controlador_rega.sv - scoreboard bench for controlador_rega with short tick timing
module tb_controlador_rega;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       inicio = 1'b0;
   logic       parar = 1'b0;
   logic [1:0] umidade = 2'b00;
   logic       nivelBaixo = 1'b0;
   logic       chuva = 1'b0;
   logic       bomba, valvulaGotejamento, valvulaAspersao, gotejamento, aspersao, alarme, ocupado;
   logic [2:0] estado;

   controlador_rega #(
      .TICK_DIV(4), .PRIME_TICKS(2), .DRIP_TICKS(5), .SPRAY_TICKS(3), .COOL_TICKS(1)
   ) dut (
      .clk(clk), .reset(reset), .inicio(inicio), .parar(parar), .umidade(umidade),
      .nivelBaixo(nivelBaixo), .chuva(chuva), .bomba(bomba),
      .valvulaGotejamento(valvulaGotejamento), .valvulaAspersao(valvulaAspersao),
      .gotejamento(gotejamento), .aspersao(aspersao), .alarme(alarme),
      .ocupado(ocupado), .estado(estado)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         tag;
      logic [9:0] v;
      string      nome;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   base = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] mk(input logic [2:0] est, input logic b, input logic vg,
                                     input logic va, input logic g, input logic a,
                                     input logic al, input logic oc);
      return {est, b, vg, va, g, a, al, oc};
   endfunction

   // Monitor: pops the expectation tagged for the current cycle and compares.
   always @(negedge clk) begin
      logic [9:0] obs;
      exp_t       e;
      obs = {estado, bomba, valvulaGotejamento, valvulaAspersao, gotejamento, aspersao, alarme, ocupado};
      while (q.size() > 0 && q[0].tag < cyc) begin
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s missed cycle tag %0d (now %0d)", e.nome, e.tag, cyc);
      end
      if (q.size() > 0 && q[0].tag == cyc) begin
         e = q.pop_front();
         checks++;
         if (obs !== e.v) begin
            errors++;
            $display("FAIL %s cyc %0d got %b want %b (est,b,vg,va,g,a,al,oc)",
                     e.nome, e.tag - base, obs, e.v);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycle(input int n);
      while (cyc < base + n) tick();
   endtask

   task automatic push_seg(input int a, input int b, input logic [9:0] v, input string nm);
      for (int n = a; n <= b; n++) q.push_back('{base + n, v, nm});
   endtask

   logic [9:0] v_idle, p_a, i_a, c_a, p_g, i_g, c_g, flt;

   task automatic push_ciclo_aspersao(input string nm);
      push_seg(1, 8, p_a, {nm, "_prime"});
      push_seg(9, 20, i_a, {nm, "_irrig"});
      push_seg(21, 24, c_a, {nm, "_cool"});
      push_seg(25, 26, v_idle, {nm, "_idle"});
   endtask

   initial begin
      int espera;
      v_idle = mk(3'd0, 0, 0, 0, 0, 0, 0, 0);
      p_a    = mk(3'd1, 1, 0, 0, 0, 1, 0, 1);
      i_a    = mk(3'd2, 1, 0, 1, 0, 1, 0, 1);
      c_a    = mk(3'd3, 0, 0, 1, 0, 1, 0, 1);
      p_g    = mk(3'd1, 1, 0, 0, 1, 0, 0, 1);
      i_g    = mk(3'd2, 1, 1, 0, 1, 0, 0, 1);
      c_g    = mk(3'd3, 0, 1, 0, 1, 0, 0, 1);
      flt    = mk(3'd4, 0, 0, 0, 0, 0, 1, 0);

      // reset state
      tick(); tick();
      base = cyc;
      push_seg(0, 0, v_idle, "reset_held");
      push_seg(1, 2, v_idle, "reset_release");
      reset = 1'b0;
      wait_cycle(2);

      // dry start, sprinkler
      base = cyc; umidade = 2'b00; inicio = 1'b1;
      push_ciclo_aspersao("seco");
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(26);

      // low moisture start, drip
      base = cyc; umidade = 2'b01; inicio = 1'b1;
      push_seg(1, 8, p_g, "baixa_prime");
      push_seg(9, 28, i_g, "baixa_irrig");
      push_seg(29, 32, c_g, "baixa_cool");
      push_seg(33, 34, v_idle, "baixa_idle");
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(34);

      // wet soil ignores inicio
      base = cyc; umidade = 2'b11; inicio = 1'b1;
      push_seg(1, 11, v_idle, "molhado");
      wait_cycle(10); inicio = 1'b0;
      wait_cycle(11);

      // tank low in IRRIGATE, then fault acknowledge
      base = cyc; umidade = 2'b01; inicio = 1'b1;
      push_seg(1, 8, p_g, "nivel_prime");
      push_seg(9, 11, i_g, "nivel_irrig");
      push_seg(12, 15, flt, "nivel_fault");
      push_seg(16, 17, v_idle, "nivel_idle");
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(11); nivelBaixo = 1'b1;
      wait_cycle(13); parar = 1'b1;
      wait_cycle(15); nivelBaixo = 1'b0;
      wait_cycle(16); parar = 1'b0;
      wait_cycle(17);

      // parar in IRRIGATE
      base = cyc; umidade = 2'b00; inicio = 1'b1;
      push_seg(1, 8, p_a, "parar_prime");
      push_seg(9, 11, i_a, "parar_irrig");
      push_seg(12, 15, c_a, "parar_cool");
      push_seg(16, 17, v_idle, "parar_idle");
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(11); parar = 1'b1;
      wait_cycle(12); parar = 1'b0;
      wait_cycle(17);

      // soil becomes wet during IRRIGATE
      base = cyc; umidade = 2'b01; inicio = 1'b1;
      push_seg(1, 8, p_g, "seca_prime");
      push_seg(9, 11, i_g, "seca_irrig");
      push_seg(12, 15, c_g, "seca_cool");
      push_seg(16, 17, v_idle, "seca_idle");
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(11); umidade = 2'b11;
      wait_cycle(17);

      // reset mid-PRIME
      base = cyc; umidade = 2'b10; inicio = 1'b1;
      push_seg(1, 3, p_g, "rst_prime");
      push_seg(4, 6, v_idle, "rst_mid");
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(3); reset = 1'b1;
      wait_cycle(4); reset = 1'b0;
      wait_cycle(6);

      // rain at start
      base = cyc; umidade = 2'b00; inicio = 1'b1; chuva = 1'b1;
`ifdef RAIN_LOCKOUT_EN
      push_seg(1, 4, v_idle, "chuva_inicio");
      espera = 4;
`else
      push_ciclo_aspersao("chuva_inicio");
      espera = 26;
`endif
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(4); chuva = 1'b0;
      wait_cycle(espera);

      // rain rising during IRRIGATE
      base = cyc; umidade = 2'b00; inicio = 1'b1;
`ifdef RAIN_LOCKOUT_EN
      push_seg(1, 8, p_a, "chuva_prime");
      push_seg(9, 10, i_a, "chuva_irrig");
      push_seg(11, 14, c_a, "chuva_cool");
      push_seg(15, 16, v_idle, "chuva_idle");
      espera = 16;
`else
      push_ciclo_aspersao("chuva_irrig");
      espera = 26;
`endif
      wait_cycle(1); inicio = 1'b0;
      wait_cycle(10); chuva = 1'b1;
      wait_cycle(12); chuva = 1'b0;
      wait_cycle(espera);

      for (int k = 0; k < 200 && q.size() > 0; k++) tick();
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending %0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
